// File: rtl/osd_spi_pkg.sv
// osd_spi_pkg: shared command codes, line size, FSM states and command-byte builder for the OSD SPI initiator
package osd_spi_pkg;

    localparam logic [3:0] CMD_WRITE      = 4'b0010;
    localparam logic [3:0] CMD_ENABLE     = 4'b0100;
    localparam int         OSD_LINE_BYTES = 256;

    typedef enum logic [2:0] {IDLE, SETUP, CMD, DATA, STALL, HOLD, GAP} state_t;

    // Small OSDs only have 8 lines, so the top line bit is forced to 0 there.
    function automatic logic [7:0] cmd_byte(input logic write, input logic [3:0] arg, input logic big);
        return write ? {CMD_WRITE, big ? arg : {1'b0, arg[2:0]}} : {CMD_ENABLE, 3'b000, arg[0]};
    endfunction

endpackage

// File: rtl/osd_spi_shifter.sv
// osd_spi_shifter: SCK half-period divider and 8-bit MSB-first serialiser
// Ports: clk_sys, reset (sync, active high); load/din start a new byte with SCK low;
//   run advances the divider (SCK frozen when low); sck/sdo drive the link;
//   byte_done flags the cycle ending the 8th high phase, where a load chains the next byte.
module osd_spi_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
    input  logic [7:0] din,
    output logic       sck,
    output logic       sdo,
    output logic       byte_done
);

    localparam int DW = $clog2(CLK_DIV + 1);

    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic          half_end, shift;

    // The shift happens on the falling edge so DO only moves while SCK is low;
    // after the last bit the register holds, keeping DO stable through a stall.
    always_comb begin
        half_end  = run && div_q == DW'(CLK_DIV - 1);
        shift     = half_end && sck_q && bit_q != 3'd7;
        byte_done = half_end && sck_q && bit_q == 3'd7;
        sck_d     = load ? 1'b0 : sck_q ^ half_end;
        div_d     = (load || half_end) ? '0 : div_q + DW'(run);
        bit_d     = load ? 3'd0 : bit_q + 3'(shift);
        sr_d      = load ? din : shift ? {sr_q[6:0], 1'b0} : sr_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sr_q  <= '0;
            bit_q <= '0;
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            bit_q <= bit_d;
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;
    assign sdo = sr_q[7];

endmodule

// File: rtl/osd_spi_tx.sv
// osd_spi_tx: SPI initiator serialising OSD ENABLE commands and WRITE-LINE bursts
// Ports: clk_sys, reset (sync, active high); cmd_valid/cmd_ready/cmd_write/cmd_arg command handshake;
//   data_valid/data/data_last payload stream, data_ready pulses when a byte is loaded;
//   busy from acceptance to end of gap; ovf pulses after 256 bytes without data_last;
//   SPI_SCK/SPI_SS3/SPI_DO link pins.
// Build option OSD_SPI_TX_FILL_EN adds cmd_fill/fill_byte: a fill WRITE sends fill_byte 256 times.
module osd_spi_tx
    import osd_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter bit BIG_OSD    = 1'b0
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [3:0] cmd_arg,
`ifdef OSD_SPI_TX_FILL_EN
    input  logic       cmd_fill,
    input  logic [7:0] fill_byte,
`endif
    input  logic       data_valid,
    input  logic [7:0] data,
    input  logic       data_last,
    output logic       data_ready,
    output logic       busy,
    output logic       ovf,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DO
);

    localparam int CW = $clog2((CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES) + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    bytes_q, bytes_d;
    logic          last_q, last_d;
    logic          write_q, write_d;
    logic          load, run, take, byte_done, sck, sdo, fill_on;
    logic [7:0]    ld_byte, fill_val;

`ifdef OSD_SPI_TX_FILL_EN
    logic       fill_q, fill_d;
    logic [7:0] fill_byte_q, fill_byte_d;

    // Captured while idle so the values at the accepting edge stick for the burst.
    always_comb begin
        fill_d      = (state_q == IDLE) ? cmd_fill : fill_q;
        fill_byte_d = (state_q == IDLE) ? fill_byte : fill_byte_q;
    end

    always_ff @(posedge clk_sys) begin
        fill_q      <= reset ? 1'b0 : fill_d;
        fill_byte_q <= reset ? 8'h00 : fill_byte_d;
    end

    assign fill_on  = fill_q;
    assign fill_val = fill_byte_q;
`else
    assign fill_on  = 1'b0;
    assign fill_val = 8'h00;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bytes_d = bytes_q;
        last_d  = last_q;
        write_d = write_q;
        load    = 1'b0;
        take    = 1'b0;
        run     = 1'b0;
        ovf     = 1'b0;
        ld_byte = fill_on ? fill_val : data;
        case (state_q)
            IDLE: if (cmd_valid) begin
                load    = 1'b1;
                ld_byte = cmd_byte(cmd_write, cmd_arg, BIG_OSD);
                write_d = cmd_write;
                bytes_d = '0;
                last_d  = 1'b0;
                cnt_d   = '0;
                state_d = SETUP;
            end
            SETUP: if (cnt_q == CW'(CLK_DIV - 1)) state_d = CMD;
            CMD, DATA: begin
                run = 1'b1;
                // Byte boundary: finish the burst, chain the next byte without a gap, or stall.
                if (byte_done) begin
                    if (state_q == CMD ? !write_q : (last_q || bytes_q == 9'(OSD_LINE_BYTES))) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        ovf     = state_q == DATA && !last_q && !fill_on && !reset;
                    end else if (fill_on || data_valid) begin
                        take = 1'b1;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: take = data_valid;
            HOLD: if (cnt_q == CW'(CLK_DIV - 1)) begin
                state_d = GAP;
                cnt_d   = '0;
            end
            GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (take) begin
            load    = 1'b1;
            bytes_d = bytes_q + 1'b1;
            last_d  = data_last && !fill_on;
            state_d = DATA;
        end
        data_ready = take && !fill_on && !reset;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bytes_q <= '0;
            last_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bytes_q <= bytes_d;
            last_q  <= last_d;
            write_q <= write_d;
        end
    end

    osd_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .load      (load),
        .run       (run),
        .din       (ld_byte),
        .sck       (sck),
        .sdo       (sdo),
        .byte_done (byte_done)
    );

    assign cmd_ready = state_q == IDLE && !reset;
    assign busy      = state_q != IDLE;
    assign SPI_SS3   = state_q == IDLE || state_q == GAP;
    assign SPI_SCK   = sck;
    assign SPI_DO    = sdo && !SPI_SS3;

endmodule

// File: tb/tb_osd_spi_tx.sv
// tb_osd_spi_tx: directed self-checking bench for osd_spi_tx with an SPI receiver model
module tb_osd_spi_tx;

    logic       clk = 1'b0;
    logic       reset, cmd_valid, cmd_write, data_valid, data_last;
    logic [3:0] cmd_arg;
    logic [7:0] data;
    logic       cmd_ready, data_ready, busy, ovf, SPI_SCK, SPI_SS3, SPI_DO;
`ifdef OSD_SPI_TX_FILL_EN
    logic       cmd_fill = 1'b0;
    logic [7:0] fill_byte = 8'h00;
`endif

    int n_chk = 0, n_err = 0;
    int n_dr = 0, n_ovf = 0, ovf_rx = 0, n_viol = 0, cyc = 0;
    logic prev_do = 1'b0;
    logic [7:0] rx[$];
    int rx_cyc[$];
    int nbit = 0;
    logic [7:0] sh = 8'h00;

    logic [8:0] tx_mem[0:299];
    int tx_n = 0, tx_idx = 0, gen = 0;
    logic hold_off = 1'b0;

    always #5 clk = ~clk;

    osd_spi_tx #(.CLK_DIV(2), .GAP_CYCLES(8), .BIG_OSD(1'b0)) dut (
        .clk_sys    (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_arg    (cmd_arg),
`ifdef OSD_SPI_TX_FILL_EN
        .cmd_fill   (cmd_fill),
        .fill_byte  (fill_byte),
`endif
        .data_valid (data_valid),
        .data       (data),
        .data_last  (data_last),
        .data_ready (data_ready),
        .busy       (busy),
        .ovf        (ovf),
        .SPI_SCK    (SPI_SCK),
        .SPI_SS3    (SPI_SS3),
        .SPI_DO     (SPI_DO)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [3:0] a);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_arg   = a;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_arg   = 4'h0;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int nb, output int ns);
        nb = 0;
        ns = 0;
        while (busy === 1'b1 && nb < budget) begin
            nb++;
            if (SPI_SS3 === 1'b0) ns++;
            tick();
        end
        chk({tag, "_timeout"}, {31'd0, busy}, 0);
    endtask

    // Receiver: samples DO on rising SCK while selected; deselect drops a partial byte.
    always @(posedge SPI_SCK or posedge SPI_SS3) begin
        if (SPI_SS3) begin
            nbit = 0;
        end else begin
            sh = {sh[6:0], SPI_DO};
            nbit++;
            if (nbit == 8) begin
                rx.push_back(sh);
                rx_cyc.push_back(cyc);
                nbit = 0;
            end
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_ready === 1'b1) n_dr++;
        if (ovf === 1'b1) begin
            n_ovf++;
            ovf_rx = rx.size();
        end
        if (SPI_SCK === 1'b1 && (SPI_DO !== prev_do || SPI_SS3 !== 1'b0)) n_viol++;
        prev_do = SPI_DO;
    end

    // Byte producer: a load happens on the edge after data_ready is seen, then the next byte is presented.
    initial begin
        int my_gen;
        logic t;
        my_gen     = 0;
        data_valid = 1'b0;
        data       = 8'h00;
        data_last  = 1'b0;
        forever begin
            @(negedge clk);
            t = data_ready;
            @(posedge clk);
            #1;
            if (gen != my_gen) begin
                my_gen = gen;
                tx_idx = 0;
            end else if (t === 1'b1) begin
                tx_idx++;
            end
            data_valid = tx_idx < tx_n && !hold_off;
            data       = tx_mem[tx_idx][7:0];
            data_last  = tx_mem[tx_idx][8];
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0, o0, nb, ns, n, bad;
        logic do_hold;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_arg   = 4'h0;
        for (int i = 0; i < 300; i++) tx_mem[i] = 9'h000;
        repeat (3) tick();
        chk("rst_ss3", {31'd0, SPI_SS3}, 1);
        chk("rst_sck", {31'd0, SPI_SCK}, 0);
        chk("rst_do", {31'd0, SPI_DO}, 0);
        chk("rst_ready", {31'd0, cmd_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_dready", {31'd0, data_ready}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", {31'd0, cmd_ready}, 1);

        // ENABLE arg=1
        base = rx.size();
        send_cmd(1'b0, 4'h1);
        chk("en_ready_busy", {31'd0, cmd_ready}, 0);
        wait_idle("en", 300, nb, ns);
        chk("en_nbytes", rx.size() - base, 1);
        chk("en_byte", rx[base], 8'h41);
        chk("en_busy_cyc", nb, 44);
        chk("en_ss_low", ns, 36);
        chk("en_ss3_idle", {31'd0, SPI_SS3}, 1);
        chk("en_ready_after", {31'd0, cmd_ready}, 1);

        // WRITE line 3 (arg bit 3 masked), A5, 3C last, back to back
        tx_mem[0] = 9'h0A5;
        tx_mem[1] = 9'h13C;
        tx_n = 2;
        gen++;
        tick();
        tick();
        base = rx.size();
        d0 = n_dr;
        o0 = n_ovf;
        send_cmd(1'b1, 4'hB);
        wait_idle("wr", 400, nb, ns);
        chk("wr_nbytes", rx.size() - base, 3);
        chk("wr_cmd", rx[base], 8'h23);
        chk("wr_b0", rx[base + 1], 8'hA5);
        chk("wr_b1", rx[base + 2], 8'h3C);
        chk("wr_period0", rx_cyc[base + 1] - rx_cyc[base], 32);
        chk("wr_period1", rx_cyc[base + 2] - rx_cyc[base + 1], 32);
        chk("wr_acks", n_dr - d0, 2);
        chk("wr_ovf", n_ovf - o0, 0);
        chk("wr_busy_cyc", nb, 108);

        // WRITE with a 50-cycle stall after byte 1
        tx_mem[0] = 9'h097;
        tx_mem[1] = 9'h15A;
        tx_n = 2;
        gen++;
        tick();
        tick();
        base = rx.size();
        d0 = n_dr;
        send_cmd(1'b1, 4'h5);
        n = 0;
        while (n_dr - d0 < 1 && n < 200) begin
            tick();
            n++;
        end
        chk("st_first_ack", n_dr - d0, 1);
        hold_off = 1'b1;
        n = 0;
        while (rx.size() - base < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("st_byte1_rx", rx.size() - base, 2);
        repeat (4) tick();
        do_hold = SPI_DO;
        bad = 0;
        repeat (50) begin
            tick();
            if (SPI_SCK !== 1'b0 || SPI_SS3 !== 1'b0 || SPI_DO !== do_hold || data_ready !== 1'b0) bad++;
        end
        chk("st_frozen", bad, 0);
        chk("st_do_hold", {31'd0, do_hold}, 1);
        hold_off = 1'b0;
        wait_idle("st", 300, nb, ns);
        chk("st_nbytes", rx.size() - base, 3);
        chk("st_cmd", rx[base], 8'h25);
        chk("st_b0", rx[base + 1], 8'h97);
        chk("st_b1", rx[base + 2], 8'h5A);
        chk("st_acks", n_dr - d0, 2);

        // 257 bytes offered, none last: 256 sent, overflow pulse, byte 257 left
        for (int i = 0; i < 257; i++) tx_mem[i] = {1'b0, 8'(i * 7 + 3)};
        tx_n = 257;
        gen++;
        tick();
        tick();
        base = rx.size();
        d0 = n_dr;
        o0 = n_ovf;
        send_cmd(1'b1, 4'h2);
        wait_idle("ov", 9000, nb, ns);
        chk("ov_nbytes", rx.size() - base, 257);
        chk("ov_cmd", rx[base], 8'h22);
        bad = 0;
        for (int i = 0; i < 256; i++) if (rx[base + 1 + i] !== 8'(i * 7 + 3)) bad++;
        chk("ov_data", bad, 0);
        chk("ov_acks", n_dr - d0, 256);
        chk("ov_pulse", n_ovf - o0, 1);
        chk("ov_after_256", ovf_rx - base, 257);
        chk("ov_left", tx_n - tx_idx, 1);
        chk("ov_busy_cyc", nb, 8236);
        chk("ov_ss3", {31'd0, SPI_SS3}, 1);
        tx_n = 0;
        gen++;
        tick();
        tick();

        // Reset in the middle of byte 2, then a clean ENABLE
        tx_mem[0] = 9'h0C3;
        tx_mem[1] = 9'h081;
        tx_mem[2] = 9'h1FF;
        tx_n = 3;
        gen++;
        tick();
        tick();
        base = rx.size();
        d0 = n_dr;
        send_cmd(1'b1, 4'h1);
        n = 0;
        while (rx.size() - base < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("rm_byte1_rx", rx.size() - base, 2);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("rm_ss3", {31'd0, SPI_SS3}, 1);
        chk("rm_sck", {31'd0, SPI_SCK}, 0);
        chk("rm_ready", {31'd0, cmd_ready}, 0);
        chk("rm_busy", {31'd0, busy}, 0);
        tick();
        reset = 1'b0;
        chk("rm_acks", n_dr - d0, 2);
        tx_n = 0;
        gen++;
        tick();
        tick();
        base = rx.size();
        send_cmd(1'b0, 4'h0);
        wait_idle("rm_en", 300, nb, ns);
        chk("rm_en_nbytes", rx.size() - base, 1);
        chk("rm_en_byte", rx[base], 8'h40);
        chk("rm_en_busy_cyc", nb, 44);

`ifdef OSD_SPI_TX_FILL_EN
        // Fill line 7 with 0x00
        cmd_fill  = 1'b1;
        fill_byte = 8'h00;
        base = rx.size();
        d0 = n_dr;
        o0 = n_ovf;
        send_cmd(1'b1, 4'h7);
        cmd_fill = 1'b0;
        wait_idle("fill", 9000, nb, ns);
        chk("fill_nbytes", rx.size() - base, 257);
        chk("fill_cmd", rx[base], 8'h27);
        bad = 0;
        for (int i = 1; i < 257; i++) if (rx[base + i] !== 8'h00) bad++;
        chk("fill_data", bad, 0);
        chk("fill_acks", n_dr - d0, 0);
        chk("fill_ovf", n_ovf - o0, 0);
`endif

        chk("do_sck_rules", n_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
